if_id_stage_unit: RTL and testbench
===================================

// Module: if_id_stage_unit
// PURPOSE
//  Fetch-side front end feeding the ID/EX pipeline register.
//  - Owns the PC register and the IF/ID pipeline register.
//  - Detects load-use hazards against the instruction currently in EX.
//  - On a hazard, stalls PC and IF/ID and asserts Control_Bubble, so ID zeroes the controls it sends into ID/EX.
//  - On a taken branch, flushes IF/ID.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction word inserted on reset and flush
//  COUNT_W    32             width of the performance counters (PERF_COUNTER_EN only)
// PORTS
//  clk                input   1   rising-edge clock
//  rst                input   1   asynchronous, active-high reset
//  Instruction_Input  input   32  instruction memory read data for PC_Output
//  Branch_Taken       input   1   branch in ID resolved taken this cycle
//  Branch_Target      input   32  target address; bits [1:0] are ignored (forced to 0)
//  ID_EX_MemRead      input   1   MemRead of the instruction now in EX
//  ID_EX_Rt           input   5   Rt of the instruction now in EX
//  PC_Output          output  32  current PC, drives instruction memory address
//  IF_ID_Instruction  output  32  registered instruction
//  IF_ID_PC_Plus4     output  32  registered PC+4 of that instruction
//  IF_ID_Rs           output  5   IF_ID_Instruction[25:21]
//  IF_ID_Rt           output  5   IF_ID_Instruction[20:16]
//  IF_ID_Rd           output  5   IF_ID_Instruction[15:11]
//  IF_ID_Valid        output  1   IF/ID holds a real (not flushed) instruction
//  Control_Bubble     output  1   combinational; ID must send all-zero controls to ID/EX
//  Stall_Count        output  COUNT_W  stall cycles (PERF_COUNTER_EN only)
//  Flush_Count        output  COUNT_W  flush cycles (PERF_COUNTER_EN only)
// BEHAVIOUR
//  Reset (async, rst=1):
//  - PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PC_Plus4=0, IF_ID_Valid=0.
//  - Counters=0. Control_Bubble=0, since IF_ID_Valid=0.
//  Hazard (combinational):
//  - Hazard = ID_EX_MemRead & IF_ID_Valid & (ID_EX_Rt!=0) & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
//  - Control_Bubble = Hazard & ~Branch_Taken.
//  Per rising edge, in priority order:
//  1. Branch_Taken: PC<=Branch_Target&~3; IF/ID<=NOP_INSTR; IF_ID_Valid<=0. Flush beats stall.
//  2. Hazard: PC, IF_ID_Instruction, IF_ID_PC_Plus4 and IF_ID_Valid all hold.
//  3. Otherwise: PC<=PC+4; IF_ID_Instruction<=Instruction_Input; IF_ID_PC_Plus4<=PC+4; IF_ID_Valid<=1.
//  Timing and boundaries:
//  - Latency: Instruction_Input appears on IF_ID_Instruction one cycle after PC_Output presents its address.
//  - PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  - A load-use stall lasts exactly 1 cycle: the bubble clears ID_EX_MemRead next cycle.
//  - Two consecutive Hazard cycles with no Branch_Taken are a protocol error; flag with an assertion.
//  - rst asserted mid-stall or mid-flush wins immediately; no pending state survives reset.
// CONFIGURATION
//  PERF_COUNTER_EN defined:
//  - Stall_Count increments on every cycle with Control_Bubble=1.
//  - Flush_Count increments on every cycle with Branch_Taken=1.
//  - Both saturate at all-ones (no wrap). Both are cleared by rst.
//  PERF_COUNTER_EN undefined: the counter ports and their logic are absent.
// STRUCTURE
//  Shared package mips_pipe_pkg:
//  - NOP_INSTR default.
//  - Field slice constants: RS_MSB/LSB, RT_MSB/LSB, RD_MSB/LSB.
//  - REG_ADDR_W=5, DATA_W=32.
//  Sub-module hazard_detect_unit:
//  - Purely combinational Hazard equation.
//  - Reused later when forwarding-aware stalls are added.
// TESTING
//  1. Reset: rst=1 mid-run -> PC=0, IF_ID_Instruction=0, IF_ID_Valid=0, Control_Bubble=0, with no clock edge needed.
//  2. Straight-line fetch: 4 cycles from PC=0 -> PC=0x10; IF_ID_PC_Plus4=0x10; IF_ID_Instruction = word fetched at 0xC.
//  3. Load-use: IF/ID holds `add $3,$2,$4`, ID_EX_MemRead=1, ID_EX_Rt=2 -> Control_Bubble=1; PC and IF/ID hold 1 cycle; advance after MemRead=0.
//  4. $zero: ID_EX_Rt=0, IF_ID_Rs=0, ID_EX_MemRead=1 -> no stall; PC advances by 4.
//  5. Flush: Branch_Taken=1, Branch_Target=0x43, Hazard also 1 -> PC=0x40; IF_ID_Instruction=NOP; IF_ID_Valid=0; Control_Bubble=0.
//  6. Wrap and counters: PC=0xFFFFFFFC -> next PC=0; with PERF_COUNTER_EN, 1 stall + 1 flush -> Stall_Count=1, Flush_Count=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the MIPS-style pipeline front end.
//  - Datapath / register-address widths.
//  - Default NOP instruction word.
//  - Instruction field slice positions (Rs, Rt, Rd) and extract helpers.
//  - Fetch-stage action encoding and the IF/ID pipeline register layout.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // All-zero word decodes as sll $0,$0,0, i.e. a harmless NOP.
    localparam logic [DATA_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // R-type register field positions.
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // What the fetch stage does on the coming clock edge.
    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_STALL = 2'd1,
        IF_FLUSH = 2'd2
    } if_action_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc_plus4;
        logic              valid;
    } if_id_reg_t;

    function automatic logic [REG_ADDR_W-1:0] field_rs(input logic [DATA_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] field_rt(input logic [DATA_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] field_rd(input logic [DATA_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage : mips_pipe_pkg

// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Purely combinational load-use hazard detector. Flags when the load now in
// EX writes a register that the instruction in IF/ID reads. Register $0 is
// never a real dependency because it is hard-wired to zero.
// Ports:
//  id_ex_mem_read_i  in   1  MemRead of the instruction in EX
//  id_ex_rt_i        in   5  destination (Rt) of the instruction in EX
//  if_id_valid_i     in   1  IF/ID holds a real instruction
//  if_id_rs_i        in   5  Rs of the instruction in IF/ID
//  if_id_rt_i        in   5  Rt of the instruction in IF/ID
//  hazard_o          out  1  load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect_unit
    import mips_pipe_pkg::*;
(
    input  logic                  id_ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic                  if_id_valid_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    output logic                  hazard_o
);

    logic rt_nonzero;
    logic src_match;

    assign rt_nonzero = (id_ex_rt_i != '0);
    assign src_match  = (id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i);

    // A flushed slot in IF/ID carries no real operands, so it never stalls.
    assign hazard_o = id_ex_mem_read_i & if_id_valid_i & rt_nonzero & src_match;

endmodule : hazard_detect_unit

// File: rtl/if_id_stage_unit.sv
// ---------------------------------------------------------------------------
// if_id_stage_unit
// Fetch-side front end feeding ID/EX: owns the PC and the IF/ID pipeline
// register, stalls for one cycle on a load-use hazard (and tells ID to send a
// bubble), and flushes IF/ID on a taken branch. Flush has priority over stall.
//
// Optional feature macro: PERF_COUNTER_EN
//  defined   -> Stall_Count / Flush_Count ports and saturating counters exist
//  undefined -> the counter ports and their logic are absent
//
// Parameters:
//  RESET_PC   PC value loaded on reset
//  NOP_INSTR  instruction word inserted on reset and flush
//  COUNT_W    performance counter width (PERF_COUNTER_EN only)
// Ports:
//  clk                in   1   rising-edge clock
//  rst                in   1   asynchronous active-high reset
//  Instruction_Input  in   32  instruction memory data for PC_Output
//  Branch_Taken       in   1   branch in ID resolved taken
//  Branch_Target      in   32  branch target (bits [1:0] ignored)
//  ID_EX_MemRead      in   1   MemRead of the instruction in EX
//  ID_EX_Rt           in   5   Rt of the instruction in EX
//  PC_Output          out  32  current PC / instruction memory address
//  IF_ID_Instruction  out  32  registered instruction
//  IF_ID_PC_Plus4     out  32  registered PC+4 of that instruction
//  IF_ID_Rs/Rt/Rd     out  5   register fields of IF_ID_Instruction
//  IF_ID_Valid        out  1   IF/ID holds a real instruction
//  Control_Bubble     out  1   ID must send all-zero controls into ID/EX
//  Stall_Count        out  COUNT_W  bubble cycles (PERF_COUNTER_EN)
//  Flush_Count        out  COUNT_W  taken-branch cycles (PERF_COUNTER_EN)
// ---------------------------------------------------------------------------
module if_id_stage_unit
    import mips_pipe_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
`ifdef PERF_COUNTER_EN
    ,
    parameter int                COUNT_W   = 32
`endif
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     Instruction_Input,
    input  logic                  Branch_Taken,
    input  logic [DATA_W-1:0]     Branch_Target,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
    output logic [DATA_W-1:0]     PC_Output,
    output logic [DATA_W-1:0]     IF_ID_Instruction,
    output logic [DATA_W-1:0]     IF_ID_PC_Plus4,
    output logic [REG_ADDR_W-1:0] IF_ID_Rs,
    output logic [REG_ADDR_W-1:0] IF_ID_Rt,
    output logic [REG_ADDR_W-1:0] IF_ID_Rd,
    output logic                  IF_ID_Valid,
    output logic                  Control_Bubble
`ifdef PERF_COUNTER_EN
    ,
    output logic [COUNT_W-1:0]    Stall_Count,
    output logic [COUNT_W-1:0]    Flush_Count
`endif
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    if_id_reg_t        if_id_q;
    if_id_reg_t        if_id_d;

    logic [DATA_W-1:0] pc_plus4;
    logic              hazard;
    if_action_e        action;

    // Wraps modulo 2^32 naturally: 32'hFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + 32'd4;

    // -----------------------------------------------------------------------
    // Hazard detection against the load in EX
    // -----------------------------------------------------------------------
    hazard_detect_unit u_hazard (
        .id_ex_mem_read_i (ID_EX_MemRead),
        .id_ex_rt_i       (ID_EX_Rt),
        .if_id_valid_i    (if_id_q.valid),
        .if_id_rs_i       (field_rs(if_id_q.instr)),
        .if_id_rt_i       (field_rt(if_id_q.instr)),
        .hazard_o         (hazard)
    );

    // A taken branch squashes the dependent instruction anyway, so no bubble
    // is needed when both happen together.
    assign Control_Bubble = hazard & ~Branch_Taken;

    // -----------------------------------------------------------------------
    // Action select: flush beats stall beats normal fetch
    // -----------------------------------------------------------------------
    always_comb begin
        action = IF_FETCH;
        if (Branch_Taken) begin
            action = IF_FLUSH;
        end else if (hazard) begin
            action = IF_STALL;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state for PC and IF/ID
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        unique case (action)
            IF_FLUSH: begin
                pc_d             = word_align(Branch_Target);
                if_id_d.instr    = NOP_INSTR;
                if_id_d.pc_plus4 = '0;
                if_id_d.valid    = 1'b0;
            end
            IF_STALL: begin
                // PC and IF/ID hold so the dependent instruction re-decodes
                // once the load data can be forwarded.
                pc_d    = pc_q;
                if_id_d = if_id_q;
            end
            IF_FETCH: begin
                pc_d             = pc_plus4;
                if_id_d.instr    = Instruction_Input;
                if_id_d.pc_plus4 = pc_plus4;
                if_id_d.valid    = 1'b1;
            end
            default: begin
                pc_d    = pc_q;
                if_id_d = if_id_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign PC_Output         = pc_q;
    assign IF_ID_Instruction = if_id_q.instr;
    assign IF_ID_PC_Plus4    = if_id_q.pc_plus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign IF_ID_Rs          = field_rs(if_id_q.instr);
    assign IF_ID_Rt          = field_rt(if_id_q.instr);
    assign IF_ID_Rd          = field_rd(if_id_q.instr);

`ifdef PERF_COUNTER_EN
    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [COUNT_W-1:0] stall_count_q;
    logic [COUNT_W-1:0] stall_count_d;
    logic [COUNT_W-1:0] flush_count_q;
    logic [COUNT_W-1:0] flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (Control_Bubble && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + COUNT_W'(1);
        end
        if (Branch_Taken && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign Stall_Count = stall_count_q;
    assign Flush_Count = flush_count_q;
`endif

    // -----------------------------------------------------------------------
    // Protocol check: a bubble must clear the load from EX, so a second
    // unresolved hazard cycle in a row means upstream control is broken.
    // -----------------------------------------------------------------------
    logic bubble_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_prev_q <= 1'b0;
        end else begin
            bubble_prev_q <= Control_Bubble;
        end
    end

    a_single_cycle_stall : assert property (
        @(posedge clk) disable iff (rst) !(bubble_prev_q && Control_Bubble)
    );

endmodule : if_id_stage_unit

// File: tb/tb_if_id_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_unit
// Directed scoreboard bench for if_id_stage_unit. The stimulus process drives
// inputs shortly after each rising edge and queues the hand-computed state
// expected at the following falling edge; an independent monitor pops and
// compares at every falling edge. Counter checks apply when PERF_COUNTER_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_if_id_stage_unit;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction_Input;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_Rt;
    logic [31:0] PC_Output;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC_Plus4;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;
    logic [4:0]  IF_ID_Rd;
    logic        IF_ID_Valid;
    logic        Control_Bubble;
`ifdef PERF_COUNTER_EN
    logic [31:0] Stall_Count;
    logic [31:0] Flush_Count;
`endif

    if_id_stage_unit dut (
        .clk               (clk),
        .rst               (rst),
        .Instruction_Input (Instruction_Input),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_Rt          (ID_EX_Rt),
        .PC_Output         (PC_Output),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC_Plus4    (IF_ID_PC_Plus4),
        .IF_ID_Rs          (IF_ID_Rs),
        .IF_ID_Rt          (IF_ID_Rt),
        .IF_ID_Rd          (IF_ID_Rd),
        .IF_ID_Valid       (IF_ID_Valid),
        .Control_Bubble    (Control_Bubble)
`ifdef PERF_COUNTER_EN
        ,
        .Stall_Count       (Stall_Count),
        .Flush_Count       (Flush_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image.
    //  0x00 add $3,$2,$4   0x04 add $7,$5,$6   0x08 add $10,$8,$9
    //  0x0C add $13,$11,$12  0x10 add $3,$2,$4  0x40 add $3,$2,$4
    //  elsewhere addi $0,$0,addr[15:0] (Rs=Rt=0)
    function automatic logic [31:0] imem(input logic [31:0] addr);
        logic [31:0] w;
        case (addr)
            32'h0000_0000: w = 32'h0044_1820;
            32'h0000_0004: w = 32'h00A6_3820;
            32'h0000_0008: w = 32'h0109_5020;
            32'h0000_000C: w = 32'h016C_6820;
            32'h0000_0010: w = 32'h0044_1820;
            32'h0000_0040: w = 32'h0044_1820;
            default:       w = {16'h2000, addr[15:0]};
        endcase
        return w;
    endfunction

    always_comb Instruction_Input = imem(PC_Output);

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        bubble;
        logic        chk_cnt;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string name, input logic [31:0] pc,
                                input logic [31:0] instr, input logic [31:0] pc4,
                                input logic chk_pc4, input logic valid,
                                input logic bubble, input logic chk_cnt,
                                input logic [31:0] stall, input logic [31:0] flush);
        exp_t e;
        e.cyc = 0; e.name = name; e.pc = pc; e.instr = instr; e.pc4 = pc4;
        e.chk_pc4 = chk_pc4; e.valid = valid; e.bubble = bubble;
        e.chk_cnt = chk_cnt; e.stall = stall; e.flush = flush;
        return e;
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Wait for an edge, drive inputs, queue what the next falling edge shows.
    task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                        input logic mr, input logic [4:0] rt, input exp_t e);
        @(posedge clk);
        #2;
        rst           = r;
        Branch_Taken  = br;
        Branch_Target = tgt;
        ID_EX_MemRead = mr;
        ID_EX_Rt      = rt;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against queued expectations at falling edges.
    initial begin
        exp_t        e;
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e  = exp_q.pop_front();
                ei = e.instr;
                if (e.cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL %s.sample actual=cycle%0d required=cycle%0d", e.name, cyc, e.cyc);
                end else begin
                    chk(e.name, "pc",     PC_Output,               e.pc);
                    chk(e.name, "instr",  IF_ID_Instruction,       ei);
                    if (e.chk_pc4) chk(e.name, "pc4", IF_ID_PC_Plus4, e.pc4);
                    chk(e.name, "valid",  {31'd0, IF_ID_Valid},    {31'd0, e.valid});
                    chk(e.name, "bubble", {31'd0, Control_Bubble}, {31'd0, e.bubble});
                    chk(e.name, "rs",     {27'd0, IF_ID_Rs},       {27'd0, ei[25:21]});
                    chk(e.name, "rt",     {27'd0, IF_ID_Rt},       {27'd0, ei[20:16]});
                    chk(e.name, "rd",     {27'd0, IF_ID_Rd},       {27'd0, ei[15:11]});
`ifdef PERF_COUNTER_EN
                    if (e.chk_cnt) begin
                        chk(e.name, "stall_cnt", Stall_Count, e.stall);
                        chk(e.name, "flush_cnt", Flush_Count, e.flush);
                    end
`endif
                    $display("txn %-16s cyc=%0d pc=%h instr=%h pc4=%h valid=%0b bubble=%0b",
                             e.name, e.cyc, PC_Output, IF_ID_Instruction,
                             IF_ID_PC_Plus4, IF_ID_Valid, Control_Bubble);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: rst, br, target, memread, rt, expected state at next negedge
    initial begin
        rst = 1'b0; Branch_Taken = 1'b0; Branch_Target = '0;
        ID_EX_MemRead = 1'b0; ID_EX_Rt = '0;
        #1 rst = 1'b1;

        step(1, 0, 32'h0, 0, 5'd0, mk("reset",        32'h0,  32'h0,        32'h0,  1, 0, 0, 1, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("reset_release",32'h0,  32'h0,        32'h0,  1, 0, 0, 1, 0, 0));
        // Straight-line fetch from 0
        step(0, 0, 32'h0, 0, 5'd0, mk("fetch_0",      32'h4,  32'h0044_1820, 32'h4,  1, 1, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("fetch_4",      32'h8,  32'h00A6_3820, 32'h8,  1, 1, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("fetch_8",      32'hC,  32'h0109_5020, 32'hC,  1, 1, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("fetch_c",      32'h10, 32'h016C_6820, 32'h10, 1, 1, 0, 0, 0, 0));
        // Flush with a simultaneous hazard (IF/ID = add $3,$2,$4, EX load to $2)
        step(0, 1, 32'h43, 1, 5'd2, mk("flush_hazard",32'h14, 32'h0044_1820, 32'h14, 1, 1, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("flush_result", 32'h40, 32'h0,        32'h0,  0, 0, 0, 0, 0, 0));
        // Load-use on Rs
        step(0, 0, 32'h0, 1, 5'd2, mk("loaduse_bubble",32'h44,32'h0044_1820, 32'h44, 1, 1, 1, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("loaduse_hold", 32'h44, 32'h0044_1820, 32'h44, 1, 1, 0, 0, 0, 0));
        // $zero never stalls
        step(0, 0, 32'h0, 1, 5'd0, mk("zero_reg",     32'h48, 32'h2000_0044, 32'h48, 1, 1, 0, 0, 0, 0));
        // Branch to the top of the address space
        step(0, 1, 32'hFFFF_FFFF, 0, 5'd0, mk("zero_advance", 32'h4C, 32'h2000_0048, 32'h4C, 1, 1, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("to_top",       32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("pc_wrap",      32'h0,  32'h2000_FFFC, 32'h0,  1, 1, 0, 1, 1, 2));
        // Load-use on Rt (EX load to $4)
        step(0, 0, 32'h0, 1, 5'd4, mk("rt_bubble",    32'h4,  32'h0044_1820, 32'h4,  1, 1, 1, 0, 0, 0));
        // Reset mid-stall, taking effect before any further edge
        step(1, 0, 32'h0, 0, 5'd0, mk("reset_midstall",32'h0, 32'h0,        32'h0,  1, 0, 0, 1, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("reset_hold",   32'h0,  32'h0,        32'h0,  1, 0, 0, 1, 0, 0));
        step(0, 0, 32'h0, 0, 5'd0, mk("after_reset",  32'h4,  32'h0044_1820, 32'h4,  1, 1, 0, 1, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_stage_unit
